// File: rtl/conv_pkg.sv
// Shared definitions for the convolution operand path: loop-nest defaults,
// counter/coordinate types and the address arithmetic used by both the
// streamer and the device-side model.
package conv_pkg;

    localparam int DEF_FEATURE_MAP_WIDTH  = 1024;
    localparam int DEF_FEATURE_MAP_HEIGHT = 1024;
    localparam int DEF_INPUT_NB_CHANNELS  = 64;
    localparam int DEF_OUTPUT_NB_CHANNELS = 64;
    localparam int DEF_KERNEL_SIZE        = 3;
    localparam int DEF_DATA_WIDTH         = 16;
    localparam int DEF_ACT_ADDR_WIDTH     = 26;
    localparam int DEF_WT_ADDR_WIDTH      = 16;

    // Offset that centres the kernel on the output pixel.
    localparam int KERNEL_HALF = DEF_KERNEL_SIZE / 2;

    localparam int NB_LOOPS  = 6;
    localparam int CNT_WIDTH = 32;

    // Loop positions, innermost first (k_h carries into k_v, and so on).
    localparam int L_KH   = 0;
    localparam int L_KV   = 1;
    localparam int L_COUT = 2;
    localparam int L_CIN  = 3;
    localparam int L_Y    = 4;
    localparam int L_X    = 5;

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef logic signed [CNT_WIDTH:0] coord_t;

    // Last value reached by the counter at loop position idx.
    function automatic cnt_t loop_last(input int idx, input int w, input int h,
                                       input int cin, input int cout, input int k);
        int n;
        case (idx)
            L_KH, L_KV: n = k;
            L_COUT:     n = cout;
            L_CIN:      n = cin;
            L_Y:        n = h;
            default:    n = w;
        endcase
        return cnt_t'(n - 1);
    endfunction

    // Input-map coordinate for an output position and kernel tap.
    function automatic coord_t in_coord(input cnt_t pos, input cnt_t tap, input int half);
        return $signed({1'b0, pos}) + $signed({1'b0, tap}) - coord_t'(half);
    endfunction

    // Linear activation address; callers keep the low bits they need.
    function automatic logic [63:0] act_addr_calc(input coord_t x_in, input coord_t y_in,
                                                  input cnt_t ch_in, input int w, input int cin);
        logic signed [63:0] v_lin;
        v_lin = 64'(y_in) * 64'(w) + 64'(x_in);
        return 64'(v_lin * 64'(cin)) + {32'd0, ch_in};
    endfunction

    // Linear weight address laid out as [ch_out][ch_in][k_v][k_h].
    function automatic logic [63:0] wt_addr_calc(input cnt_t ch_out, input cnt_t ch_in,
                                                 input cnt_t k_v, input cnt_t k_h,
                                                 input int cin, input int k);
        logic [63:0] v;
        v = {32'd0, ch_out} * 64'(cin) + {32'd0, ch_in};
        v = v * 64'(k) + {32'd0, k_v};
        v = v * 64'(k) + {32'd0, k_h};
        return v;
    endfunction

endpackage

// File: rtl/conv_loop_nest.sv
// Six-deep counter nest (x, y, ch_in, ch_out, k_v, k_h). Each counter wraps
// at its last value and carries into the next outer one on advance.
module conv_loop_nest
    import conv_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
    parameter int INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
    parameter int KERNEL_SIZE        = DEF_KERNEL_SIZE
)(
    input  logic                               clk,
    input  logic                               srst,
    input  logic                               advance,
    input  logic                               clear,
    output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] cnt,
    output logic [NB_LOOPS-1:0]                last,
    output logic                               last_overall
);

    cnt_t              r_cnt [NB_LOOPS];
    logic [NB_LOOPS:0] w_carry;

    assign w_carry[0]   = advance;
    assign last_overall = &last;

    genvar gi;
    generate
        for (gi = 0; gi < NB_LOOPS; gi++) begin : g_cnt
            localparam cnt_t LAST_VAL = loop_last(gi, FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                                                  INPUT_NB_CHANNELS, OUTPUT_NB_CHANNELS,
                                                  KERNEL_SIZE);

            assign last[gi]        = (r_cnt[gi] == LAST_VAL);
            assign w_carry[gi + 1] = w_carry[gi] & last[gi];
            assign cnt[gi]         = r_cnt[gi];

            // Step when every inner counter is wrapping; wrap to zero at the end.
            always_ff @(posedge clk) begin
                if (srst || clear) begin
                    r_cnt[gi] <= '0;
                end else if (w_carry[gi]) begin
                    r_cnt[gi] <= last[gi] ? '0 : r_cnt[gi] + cnt_t'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/operand_streamer.sv
// Host-side operand producer: walks the conv loop nest, reads activation and
// weight memories, and presents one (a, b) pair per MAC with zero padding at
// feature-map borders. Each op costs one READ cycle plus one or more PRESENT
// cycles, so the pair is always offered together and held until accepted.
module operand_streamer
    import conv_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
    parameter int INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
    parameter int KERNEL_SIZE        = DEF_KERNEL_SIZE,
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int ACT_ADDR_WIDTH     = DEF_ACT_ADDR_WIDTH,
    parameter int WT_ADDR_WIDTH      = DEF_WT_ADDR_WIDTH
)(
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      start,
    output logic                      running,
    output logic                      done,
    output logic                      act_re,
    output logic [ACT_ADDR_WIDTH-1:0] act_addr,
    input  logic [DATA_WIDTH-1:0]     act_rdata,
    output logic                      wt_re,
    output logic [WT_ADDR_WIDTH-1:0]  wt_addr,
    input  logic [DATA_WIDTH-1:0]     wt_rdata,
    output logic [DATA_WIDTH-1:0]     a_input,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [DATA_WIDTH-1:0]     b_input,
    output logic                      b_valid,
    input  logic                      b_ready
);

    localparam int K_HALF = KERNEL_SIZE / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_pad_q;

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] w_cnt;
    logic [NB_LOOPS-1:0]                w_last;
    logic                               w_last_overall;
    logic                               w_advance;
    logic                               w_clear;
    logic                               w_pad;
    coord_t                             w_x_in;
    coord_t                             w_y_in;
    logic [63:0]                        w_act_addr_full;
    logic [63:0]                        w_wt_addr_full;
    logic                               w_unused_bits;

    conv_loop_nest #(
        .FEATURE_MAP_WIDTH  (FEATURE_MAP_WIDTH),
        .FEATURE_MAP_HEIGHT (FEATURE_MAP_HEIGHT),
        .INPUT_NB_CHANNELS  (INPUT_NB_CHANNELS),
        .OUTPUT_NB_CHANNELS (OUTPUT_NB_CHANNELS),
        .KERNEL_SIZE        (KERNEL_SIZE)
    ) u_nest (
        .clk          (clk),
        .srst         (rst_in),
        .advance      (w_advance),
        .clear        (w_clear),
        .cnt          (w_cnt),
        .last         (w_last),
        .last_overall (w_last_overall)
    );

    // Input-map coordinates of the current tap; outside the map means padding.
    assign w_x_in = in_coord(w_cnt[L_X], w_cnt[L_KH], K_HALF);
    assign w_y_in = in_coord(w_cnt[L_Y], w_cnt[L_KV], K_HALF);
    assign w_pad  = w_x_in[CNT_WIDTH] || (w_x_in >= coord_t'(FEATURE_MAP_WIDTH)) ||
                    w_y_in[CNT_WIDTH] || (w_y_in >= coord_t'(FEATURE_MAP_HEIGHT));

    assign w_act_addr_full = act_addr_calc(w_x_in, w_y_in, w_cnt[L_CIN],
                                           FEATURE_MAP_WIDTH, INPUT_NB_CHANNELS);
    assign w_wt_addr_full  = wt_addr_calc(w_cnt[L_COUT], w_cnt[L_CIN], w_cnt[L_KV],
                                          w_cnt[L_KH], INPUT_NB_CHANNELS, KERNEL_SIZE);

    // Upper address bits are dropped by design; per-loop last flags are not needed here.
    assign w_unused_bits = ^{w_act_addr_full[63:ACT_ADDR_WIDTH],
                             w_wt_addr_full[63:WT_ADDR_WIDTH], w_last};

    // State register.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Remember whether the op being read is padded, so PRESENT can force zero.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_pad_q <= 1'b0;
        end else if (r_state == S_READ) begin
            r_pad_q <= w_pad;
        end
    end

    // Next-state, counter control and all port outputs.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_clear      = 1'b0;
        running      = 1'b0;
        done         = 1'b0;
        act_re       = 1'b0;
        act_addr     = '0;
        wt_re        = 1'b0;
        wt_addr      = '0;
        a_input      = '0;
        a_valid      = 1'b0;
        b_input      = '0;
        b_valid      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                running      = 1'b1;
                wt_re        = 1'b1;
                wt_addr      = w_wt_addr_full[WT_ADDR_WIDTH-1:0];
                act_re       = !w_pad;
                if (!w_pad) begin
                    act_addr = w_act_addr_full[ACT_ADDR_WIDTH-1:0];
                end
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                running = 1'b1;
                a_valid = 1'b1;
                b_valid = 1'b1;
                a_input = r_pad_q ? '0 : act_rdata;
                b_input = wt_rdata;
                if (a_ready && b_ready) begin
                    if (w_last_overall) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                running      = 1'b1;
                done         = 1'b1;
                w_clear      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
